// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - shared state type and default geometry for serial_frame_ctrl
package seq_ctrl_pkg;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam int          DEF_PAT_W   = 4;
   localparam logic [3:0]  DEF_PATTERN = 4'b1101;
   localparam int          DEF_CNT_W   = 4;

endpackage

// File: rtl/serial_frame_ctrl_one_pulser.sv
// rtl/serial_frame_ctrl_one_pulser.sv - one_pulser: single-cycle step per rising edge of a level request
// SEQ_CTRL_SYNC_EN adds a 2-flop synchronizer and a registered pulse (3-cycle lag).
module one_pulser (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic pulse
);

`ifdef SEQ_CTRL_SYNC_EN
   logic sync1_q, sync2_q, prev_q, pulse_q;

   // Synchronizer flops reset high too, so a request held through reset stays edge-free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         pulse_q <= sync2_q & ~prev_q;
      end
   end

   assign pulse = pulse_q;
`else
   logic prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= in;
      end
   end

   assign pulse = in & ~prev_q;
`endif

endmodule

// File: rtl/serial_frame_ctrl.sv
// rtl/serial_frame_ctrl.sv - start-pattern hunt and length-counted payload forwarding
// Optional SEQ_CTRL_SYNC_EN selects the synchronized step path in one_pulser.
module serial_frame_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
   parameter int               CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clkEN,
   input  logic             SerIn,
   input  logic [CNT_W-1:0] len,
   output logic             SerOut,
   output logic             SerOutValid,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             step;
   seq_state_t       state_q, state_d;
   logic [PAT_W-1:0] sr_q, sr_d, sr_shift;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sout_q, sout_d;
   logic             valid_q, valid_d;
   logic             match;

   one_pulser u_pulser (
      .clk   (clk),
      .rst   (rst),
      .in    (clkEN),
      .pulse (step)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= HUNT;
         sr_q    <= '0;
         cnt_q   <= '0;
         sout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         sout_q  <= sout_d;
         valid_q <= valid_d;
      end
   end

   assign sr_shift = {sr_q[PAT_W-2:0], SerIn};
   assign match    = (sr_shift == PATTERN);

   // The shift register only moves in HUNT, so payload bits can never re-trigger detection.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      sout_d  = sout_q;
      valid_d = 1'b0;
      unique case (state_q)
         HUNT: begin
            if (step) begin
               if (match) begin
                  sr_d    = '0;
                  cnt_d   = len;
                  state_d = XFER;
               end else begin
                  sr_d = sr_shift;
               end
            end
         end
         XFER: begin
            if (step) begin
               sout_d  = SerIn;
               valid_d = 1'b1;
               cnt_d   = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = HUNT;
         end
         default: begin
            state_d = HUNT;
         end
      endcase
   end

   always_comb begin
      busy        = (state_q != HUNT);
      frame_done  = (state_q == DONE);
      SerOut      = sout_q;
      SerOutValid = valid_q;
      bit_cnt     = cnt_q;
   end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// tb/tb_serial_frame_ctrl.sv - randomized self-checking bench for serial_frame_ctrl against a frame-level model
module tb_serial_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       clkEN;
   logic       SerIn;
   logic [3:0] len;
   logic       SerOut;
   logic       SerOutValid;
   logic       busy;
   logic       frame_done;
   logic [3:0] bit_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   serial_frame_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .clkEN       (clkEN),
      .SerIn       (SerIn),
      .len         (len),
      .SerOut      (SerOut),
      .SerOutValid (SerOutValid),
      .busy        (busy),
      .frame_done  (frame_done),
      .bit_cnt     (bit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Frame-level model: sampled-bit history, remaining payload bits, last forwarded bit.
   int m_forwarding;
   int m_hist[$];
   int m_rem;
   int m_out;
   int m_cnt;
   int m_valid;
   int m_done;

   function automatic void model_reset();
      m_forwarding = 0;
      m_hist.delete();
      m_rem   = 0;
      m_out   = 0;
      m_cnt   = 0;
      m_valid = 0;
      m_done  = 0;
   endfunction

   function automatic void model_step(input int b, input int l);
      logic [3:0] pat;
      bit hit;
      pat     = 4'b1101;
      m_valid = 0;
      m_done  = 0;
      if (m_forwarding == 0) begin
         m_hist.push_back(b);
         if (m_hist.size() > 4) void'(m_hist.pop_front());
         hit = (m_hist.size() == 4);
         for (int i = 0; i < 4; i++)
            if (m_hist.size() == 4 && m_hist[i] != int'(pat[3-i])) hit = 0;
         if (hit) begin
            m_forwarding = 1;
            m_rem = (l == 0) ? 16 : l;
            m_cnt = l;
            m_hist.delete();
         end
      end else begin
         m_out   = b;
         m_valid = 1;
         m_rem   = m_rem - 1;
         m_cnt   = m_rem % 16;
         if (m_rem == 0) begin
            m_forwarding = 0;
            m_done = 1;
         end
      end
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_serout"},  SerOut,      0);
      check({tag, "_valid"},   SerOutValid, 0);
      check({tag, "_busy"},    busy,        0);
      check({tag, "_done"},    frame_done,  0);
      check({tag, "_bitcnt"},  bit_cnt,     0);
   endtask

   // One clkEN high phase of 'hold' cycles with SerIn=b, then at least one low cycle.
   task automatic do_step(input logic b, input int hold);
      int extra;
      @(negedge clk);
      clkEN = 1'b1;
      SerIn = b;
      model_step(int'(b), int'(len));
      @(negedge clk);
      check("valid",  SerOutValid, m_valid);
      check("bitcnt", bit_cnt,     m_cnt);
      check("serout", SerOut,      m_out);
      check("done",   frame_done,  m_done);
      check("busy",   busy,        (m_forwarding != 0 || m_done != 0) ? 1 : 0);
      if (hold == 1) clkEN = 1'b0;
      @(negedge clk);
      check("valid_clr", SerOutValid, 0);
      check("done_clr",  frame_done,  0);
      check("busy_post", busy,        m_forwarding);
      extra = 0;
      for (int i = 2; i < hold; i++) begin
         @(negedge clk);
         if (SerOutValid) extra++;
      end
      if (hold > 1) begin
         clkEN = 1'b0;
         check("dup_valid", extra, 0);
      end
      m_done = 0;
   endtask

   // Reset with clkEN held high across assertion and release.
   task automatic do_reset();
      @(negedge clk);
      clkEN = 1'b1;
      SerIn = 1'b1;
      #2 rst = 1'b0;
      #1 check_idle_outputs("rst_async");
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_hold_valid", SerOutValid, 0);
      end
      check("rst_hold_busy", busy, 0);
      clkEN = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) do_step(bits[i], 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int steps;
      logic b;
      rst   = 1'b0;
      clkEN = 1'b0;
      SerIn = 1'b0;
      len   = 4'd0;
      model_reset();
      #3 check_idle_outputs("por");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Reset mid-stream with clkEN high; the held-high request must not create a step.
      len = 4'd3;
      send_bits(32'b110, 3);
      do_reset();
      send_bits(32'b101, 3);
      check("no_detect_after_rst", busy, 0);

      // Basic frame: detection on step 5, three payload bits, then a HUNT shift.
      do_reset();
      len = 4'd3;
      send_bits(32'b011010110, 9);

      // Overlapping detection followed by an embedded pattern in the payload.
      len = 4'd4;
      send_bits(32'b11101, 5);
      send_bits(32'b1101, 4);
      check("overlap_end_busy", busy, 0);

      // Long clkEN high phase in HUNT and in XFER.
      len = 4'd2;
      do_step(1'b1, 20);
      send_bits(32'b101, 3);
      do_step(1'b0, 20);
      do_step(1'b1, 1);

      // len = 0 forwards 2^CNT_W bits.
      len = 4'd0;
      send_bits(32'b1101, 4);
      for (int i = 0; i < 16; i++) do_step(1'($urandom_range(0, 1)), 1);
      check("len0_end_busy", busy, 0);

      // Reset during XFER, then partial and full patterns.
      len = 4'd3;
      send_bits(32'b110110, 6);
      do_reset();
      check("xfer_rst_busy", busy, 0);
      check("xfer_rst_cnt", bit_cnt, 0);
      send_bits(32'b101, 3);
      check("partial_no_detect", busy, 0);
      send_bits(32'b1101, 4);
      check("full_detect", busy, 1);
      send_bits(32'b010, 3);

      // Randomized frames with occasional long holds and resets.
      for (int f = 0; f < 30; f++) begin
         if (m_forwarding == 0) len = 4'($urandom_range(0, 15));
         steps = 0;
         while (steps < 120) begin
            b = 1'($urandom_range(0, 1));
            do_step(b, ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 5)) : 1);
            steps++;
            if ($urandom_range(0, 80) == 0) do_reset();
            if (m_forwarding == 0 && steps > 4 && $urandom_range(0, 3) == 0) break;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_frame_ctrl.md
# serial_frame_ctrl

Controller that sequences the serial detect-and-forward datapath in the lab design. It turns the raw `clkEN` step request into single-cycle sample strobes and hunts the sampled `SerIn` stream for a start pattern. It then owns the payload counter, forwarding exactly `len` bits to `SerOut` with `SerOutValid`, and signals frame completion. It replaces the loose `inc_cnt`/`rst_cnt`/`cout` handshake between the detector and an external counter with one self-contained block.

## Interface
- `PAT_W`, 4, start-pattern width in bits
- `PATTERN`, 4'b1101, start pattern; MSB is the oldest sampled bit
- `CNT_W`, 4, payload counter width
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `clkEN`  in  1  raw step request, level (push-button); one step per rising edge
- `SerIn`  in  1  serial data, sampled only on a step
- `len`  in  CNT_W  payload length in bits; 0 means 2^CNT_W; sampled at pattern detection
- `SerOut`  out  1  forwarded payload bit, registered
- `SerOutValid`  out  1  one-cycle pulse marking a new `SerOut` bit
- `busy`  out  1  high while in XFER or DONE
- `frame_done`  out  1  one-cycle pulse after the last payload bit
- `bit_cnt`  out  CNT_W  payload bits remaining

## Operation
- `one_pulser` produces `step` for exactly one cycle per `clkEN` rising edge. Holding `clkEN` high yields one step.
- The edge register resets to 1. `clkEN` held high through reset release produces no step until it is seen low.
- States:
  - HUNT (reset state):
    - each step shifts `SerIn` into a `PAT_W` shift register (`{sr[PAT_W-2:0], SerIn}`).
    - If the new value equals `PATTERN`: load `bit_cnt` with `len`, clear the shift register, go to XFER.
    - Detection is overlapping: leading bits may be reused.
  - XFER:
    - each step sets `SerOut <= SerIn`, pulses `SerOutValid`, and decrements `bit_cnt` (mod 2^CNT_W).
    - The step taken with `bit_cnt == 1` goes to DONE.
    - If `len == 0` was loaded, `bit_cnt` wraps 0→2^CNT_W−1 on the first step, giving 2^CNT_W bits total.
    - The shift register is frozen, so patterns inside the payload are ignored.
  - DONE: `frame_done = 1` for one cycle; `bit_cnt = 0`; unconditionally return to HUNT. A step arriving in DONE is dropped.
- `SerOut` holds its last value between steps and after the frame.
- `busy` is decoded from state.

## Timing
- Reset values:
  - `SerOut=0`, `SerOutValid=0`, `busy=0`, `frame_done=0`, `bit_cnt=0`
  - shift register 0
  - state HUNT
- Reset wins over any coincident step. Reset mid-frame abandons the frame, and the next frame needs a full new pattern.
- With `SEQ_CTRL_SYNC_EN`:
  - `step` is high in the 3rd cycle after the edge that first samples `clkEN=1`.
  - `SerIn` is sampled on the edge closing that cycle.
- The state change, `bit_cnt` update and `SerOut` update take effect on that same edge.
- `SerOutValid` is high in the following cycle only.
- `frame_done` is high in the cycle after the edge of the last payload step.
- Minimum step spacing is 2 cycles between `clkEN` edges. This is guaranteed by the low phase of `clkEN`.

## Configuration
- `SEQ_CTRL_SYNC_EN`
  - defined: `one_pulser` places a 2-flop synchronizer ahead of the edge register. `step` lags `clkEN` by 3 cycles.
  - undefined: edge detect on `clkEN` directly with one register (`step = clkEN & ~prev`, combinational). `step` is valid in the cycle `clkEN` is first sampled high. This mode is for fully synchronous testbenches only.

## Structure
- Package `seq_ctrl_pkg`:
  - state typedef `seq_state_t` {HUNT, XFER, DONE}
  - default `PAT_W`, `PATTERN`, `CNT_W` localparams
- Sub-module `one_pulser`: clk, rst, in → pulse, with the synchronizer under `SEQ_CTRL_SYNC_EN`.
- Top module contains the FSM, shift register, counter and output registers.

## Test plan
Defaults `PATTERN=1101`, `CNT_W=4`.

1. Reset: assert `rst=0` mid-stream with `clkEN` high. All outputs go to reset values immediately. After release with `clkEN` still high, there is no step until `clkEN` toggles.
2. `len=3`, steps with `SerIn` 0,1,1,0,1,0,1,1,0:
   - detection on step 5
   - steps 6–8 give `SerOut` 0,1,1 with three `SerOutValid` pulses and `bit_cnt` 3→2→1→0
   - one `frame_done` pulse
   - step 9 shifts 0 in HUNT
3. Overlap: `SerIn` 1,1,1,0,1 detects on step 5. Then 1,1,0,1 sent as payload (`len=4`) is forwarded with no re-detection.
4. `clkEN` held high for 20 cycles, then low. This produces exactly one step, one shift, and no duplicate `SerOutValid`.
5. `len=0`: after detection, exactly 16 `SerOutValid` pulses occur. `bit_cnt` goes 0→15→…→1, then `frame_done`.
6. Reset during XFER after 2 of 3 payload bits. `busy` drops and `bit_cnt=0`. A following 1,0,1 does not detect; a full 1,1,0,1 does.
